instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Instruction fetch front end. Issues word-aligned fetch requests,
//            keeps a 2-entry in-order {instr, pc} buffer for decode, and
//            flushes in-flight fetches on a control-flow redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

   logic [1:0]  state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   // Decode buffer, entry 0 is the head presented to decode
   logic [31:0] b0_instr_q, b0_instr_d, b0_pc_q, b0_pc_d;
   logic [31:0] b1_instr_q, b1_instr_d, b1_pc_q, b1_pc_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] plus4_q, plus4_d;
   // Tag queue of PCs for live outstanding requests, entry 0 is oldest
   logic [31:0] t0_pc_q, t0_pc_d, t1_pc_q, t1_pc_d;
   logic [1:0]  tcnt_q, tcnt_d;
   // Responses still owed for requests abandoned by a redirect
   logic [1:0]  disc_q, disc_d;

   logic [2:0]  w_sum;
   logic        w_req_hs;
   logic        w_out_hs;
   logic        w_rsp_live;
   logic [1:0]  w_tcnt_tmp;
   logic [1:0]  w_bcnt_tmp;
   logic [2:0]  w_pend;

   // Discarded requests count as outstanding, so the total never exceeds two
   assign w_sum          = {1'b0, bcnt_q} + {1'b0, tcnt_q} + {1'b0, disc_q};
   assign imem_req_valid = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && (w_sum < 3'd2);
   assign imem_req_addr  = fpc_q & C_ALIGN_MASK;
   assign w_req_hs       = imem_req_valid && imem_req_ready;
   assign w_out_hs       = out_valid && out_ready;

   assign out_valid      = (bcnt_q != 2'd0);
   assign out_instr      = b0_instr_q;
   assign out_pc         = b0_pc_q;
   assign out_pc_plus4   = plus4_q;

   // Next-state: redirect wins over everything except the decode handshake
   always_comb begin
      state_d    = state_q;
      fpc_d      = fpc_q;
      b0_instr_d = b0_instr_q;
      b0_pc_d    = b0_pc_q;
      b1_instr_d = b1_instr_q;
      b1_pc_d    = b1_pc_q;
      bcnt_d     = bcnt_q;
      t0_pc_d    = t0_pc_q;
      t1_pc_d    = t1_pc_q;
      tcnt_d     = tcnt_q;
      disc_d     = disc_q;
      w_rsp_live = 1'b0;
      w_tcnt_tmp = tcnt_q;
      w_bcnt_tmp = bcnt_q;
      w_pend     = 3'd0;

      if (redirect_valid) begin
         fpc_d  = redirect_pc & C_ALIGN_MASK;
         bcnt_d = 2'd0;
         tcnt_d = 2'd0;
         // Everything in flight, including a request accepted right now,
         // becomes a discard; a response arriving now retires the oldest one.
         w_pend = {1'b0, disc_q} + {1'b0, tcnt_q} + {2'b00, w_req_hs};
         if (imem_rsp_valid && ((disc_q != 2'd0) || (tcnt_q != 2'd0)))
            w_pend = w_pend - 3'd1;
         disc_d = (w_pend > 3'd2) ? 2'd2 : w_pend[1:0];
      end else begin
         if (w_req_hs)
            fpc_d = fpc_q + 32'd4;

         // Responses return in order: owed discards are always older
         if (imem_rsp_valid) begin
            if (disc_q != 2'd0)
               disc_d = disc_q - 2'd1;
            else if (tcnt_q != 2'd0)
               w_rsp_live = 1'b1;
         end

         if (w_rsp_live) begin
            t0_pc_d    = t1_pc_q;
            w_tcnt_tmp = tcnt_q - 2'd1;
         end
         if (w_req_hs) begin
            if (w_tcnt_tmp == 2'd0)
               t0_pc_d = fpc_q & C_ALIGN_MASK;
            else
               t1_pc_d = fpc_q & C_ALIGN_MASK;
         end
         tcnt_d = w_tcnt_tmp + {1'b0, w_req_hs};

         if (w_out_hs) begin
            b0_instr_d = b1_instr_q;
            b0_pc_d    = b1_pc_q;
            w_bcnt_tmp = bcnt_q - 2'd1;
         end
         if (w_rsp_live) begin
            if (w_bcnt_tmp == 2'd0) begin
               b0_instr_d = imem_rsp_data;
               b0_pc_d    = t0_pc_q;
            end else begin
               b1_instr_d = imem_rsp_data;
               b1_pc_d    = t0_pc_q;
            end
         end
         bcnt_d = w_bcnt_tmp + {1'b0, w_rsp_live};
      end

      plus4_d = b0_pc_d + 32'd4;

      case (state_q)
         ST_BOOT:  state_d = ST_RUN;
         ST_RUN:   if (redirect_valid && (disc_d != 2'd0)) state_d = ST_FLUSH;
         ST_FLUSH: if (!redirect_valid && (disc_d == 2'd0)) state_d = ST_RUN;
         default:  state_d = ST_BOOT;
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         fpc_q      <= RESET_PC & C_ALIGN_MASK;
         b0_instr_q <= 32'd0;
         b0_pc_q    <= 32'd0;
         b1_instr_q <= 32'd0;
         b1_pc_q    <= 32'd0;
         bcnt_q     <= 2'd0;
         plus4_q    <= 32'd0;
         t0_pc_q    <= 32'd0;
         t1_pc_q    <= 32'd0;
         tcnt_q     <= 2'd0;
         disc_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         b0_instr_q <= b0_instr_d;
         b0_pc_q    <= b0_pc_d;
         b1_instr_q <= b1_instr_d;
         b1_pc_q    <= b1_pc_d;
         bcnt_q     <= bcnt_d;
         plus4_q    <= plus4_d;
         t0_pc_q    <= t0_pc_d;
         t1_pc_q    <= t1_pc_d;
         tcnt_q     <= tcnt_d;
         disc_q     <= disc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit. A behavioural memory
//            answers requests in order; the delivered stream must follow the
//            program order rule (next pc = pc+4, or the latest redirect target)
//            with each word equal to the memory contents at that pc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;

   instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus knobs, percent probabilities
   int p_rdy = 100, p_rsp = 100, p_ordy = 100, p_redir = 0, p_spur = 0;

   logic [31:0] mq[$];        // requests accepted by memory, not yet answered
   logic [31:0] req_log[$];   // accepted request addresses
   logic [31:0] del_log[$];   // delivered pcs
   logic [31:0] exp_pc;
   logic        stall_prev;
   logic [31:0] stall_addr;

   logic        redir_once = 1'b0;
   logic [31:0] redir_tgt  = 32'd0;
   logic        arm_en = 1'b0, arm_fired = 1'b0;
   logic [31:0] arm_pc, arm_addr, arm_tgt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_BEEF;
   endfunction

   // One clock cycle: drive inputs after the falling edge, then score the
   // handshakes that the next rising edge will commit.
   task automatic cycle();
      @(negedge clk);
      imem_req_ready = ($urandom_range(99) < p_rdy);
      out_ready      = ($urandom_range(99) < p_ordy);
      imem_rsp_data  = $urandom;
      imem_rsp_valid = 1'b0;
      if (mq.size() > 0) begin
         if ($urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq.pop_front());
         end
      end else if ($urandom_range(99) < p_spur) begin
         imem_rsp_valid = 1'b1;
      end
      redirect_valid = 1'b0;
      if (redir_once) begin
         redirect_valid = 1'b1;
         redirect_pc    = redir_tgt;
         redir_once     = 1'b0;
      end else if ($urandom_range(99) < p_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
      end
      #1;
      if (arm_en && out_valid && out_ready && (out_pc == arm_pc) &&
          imem_req_valid && imem_req_ready && (imem_req_addr == arm_addr)) begin
         redirect_valid = 1'b1;
         redirect_pc    = arm_tgt;
         arm_en         = 1'b0;
         arm_fired      = 1'b1;
      end
      #1;
      if (stall_prev) begin
         check("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
         check("req_hold_addr", imem_req_addr, stall_addr);
      end
      if (imem_req_valid && imem_req_ready) begin
         check("req_align", imem_req_addr & 32'h3, 32'd0);
         mq.push_back(imem_req_addr);
         req_log.push_back(imem_req_addr);
         check("inflight_le2", {31'd0, mq.size() > 2}, 32'd0);
      end
      if (out_valid && out_ready) begin
         check("out_pc", out_pc, exp_pc);
         check("out_instr", out_instr, mem_word(out_pc));
         check("out_pc_plus4", out_pc_plus4, out_pc + 32'd4);
         del_log.push_back(out_pc);
         exp_pc = out_pc + 32'd4;
      end
      if (redirect_valid)
         exp_pc = redirect_pc & 32'hFFFF_FFFC;
      stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid;
      stall_addr = imem_req_addr;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Asynchronous reset pulse away from both clock edges
   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_plus4", out_pc_plus4, 32'd0);
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      mq.delete();
      req_log.delete();
      del_log.delete();
      exp_pc     = RESET_PC;
      stall_prev = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
   endtask

   task automatic knobs(input int r, input int s, input int o, input int d, input int sp);
      p_rdy = r; p_rsp = s; p_ordy = o; p_redir = d; p_spur = sp;
   endtask

   initial begin
      exp_pc     = RESET_PC;
      stall_prev = 1'b0;
      #12;
      do_reset();

      // Streaming fetch with immediate memory and free-running decode
      knobs(100, 100, 100, 0, 0);
      run(12);
      check("seq_req0", q_at(req_log, 0), 32'h0);
      check("seq_req1", q_at(req_log, 1), 32'h4);
      check("seq_req2", q_at(req_log, 2), 32'h8);
      check("seq_del0", q_at(del_log, 0), 32'h0);
      check("seq_del2", q_at(del_log, 2), 32'h8);

      // Decode back-pressure fills the two slots and stops fetching
      do_reset();
      knobs(100, 100, 0, 0, 0);
      run(10);
      check("bp_req_count", req_log.size(), 32'd2);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_pc", out_pc, 32'h0);
      p_ordy = 100;
      run(10);
      check("bp_del0", q_at(del_log, 0), 32'h0);
      check("bp_del1", q_at(del_log, 1), 32'h4);
      check("bp_resume", q_at(req_log, 2), 32'h8);

      // Redirect with two requests outstanding
      do_reset();
      knobs(100, 0, 100, 0, 0);
      run(3);
      check("rd_outstanding", mq.size(), 32'd2);
      p_rsp      = 100;
      redir_tgt  = 32'h100;
      redir_once = 1'b1;
      run(12);
      check("rd_del0", q_at(del_log, 0), 32'h100);
      check("rd_del1", q_at(del_log, 1), 32'h104);

      // Redirect coinciding with a request at 0x20 and delivery of 0x1C
      do_reset();
      knobs(100, 100, 100, 0, 0);
      arm_pc = 32'h1C; arm_addr = 32'h20; arm_tgt = 32'h200;
      arm_en = 1'b1; arm_fired = 1'b0;
      run(40);
      arm_en = 1'b0;
      check("same_cycle_fired", {31'd0, arm_fired}, 32'd1);
      begin
         int idx = -1;
         for (int i = 0; i < del_log.size(); i++)
            if (del_log[i] == 32'h1C) idx = i;
         check("same_cycle_1c_delivered", {31'd0, idx >= 0}, 32'd1);
         check("same_cycle_next", q_at(del_log, idx + 1), 32'h200);
      end

      // Redirect to an unaligned target at the top of the address space
      redir_tgt  = 32'hFFFF_FFFE;
      redir_once = 1'b1;
      cycle();
      del_log.delete();
      run(12);
      check("wrap_del0", q_at(del_log, 0), 32'hFFFF_FFFC);
      check("wrap_del1", q_at(del_log, 1), 32'h0000_0000);

      // Memory stall holds the request; reset mid-stall restarts fetch
      do_reset();
      knobs(0, 100, 100, 0, 0);
      run(7);
      check("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_addr", imem_req_addr, RESET_PC);
      do_reset();
      knobs(100, 100, 100, 0, 0);
      run(5);
      check("restart_addr", q_at(req_log, 0), RESET_PC);

      // Randomised traffic, reset asynchronously between segments
      for (int seg = 0; seg < 5; seg++) begin
         do_reset();
         knobs($urandom_range(100, 30), $urandom_range(100, 30),
               $urandom_range(100, 30), $urandom_range(8, 0), $urandom_range(30, 0));
         run(500);
         check("rand_progress", {31'd0, del_log.size() > 10}, 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
